key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/tetris_input_pkg.sv | 27 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/key_conditioner.sv | 113 +++++++++++
 3 files changed

// File: rtl/tetris_input_pkg.sv
// Shared key indices, repeat-state encoding and default timing for the Tetris
// key input path.
package tetris_input_pkg;

  localparam int NUM_KEYS  = 4;

  localparam int KEY_ROT   = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_DOWN  = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_RATE     = 5000000;
  localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = 4'b1110;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a run-length debouncer. o_rise/o_fall
// flag the edge on which o_held is about to change, so a registered consumer
// lines up with the first cycle of the new level.
module key_debounce
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic srst,
  input  logic i_raw,
  output logic o_held,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_held;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_differs;
  logic          w_toggle;

  assign w_differs = (r_sync2 != r_held);
  assign w_toggle  = w_differs && (r_cnt == CNT_LAST);

  // Any agreeing sample restarts the run; the count holds at its last value.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_differs || w_toggle) begin
      w_cnt_next = '0;
    end else if (r_cnt != CNT_LAST) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_held  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;
      if (w_toggle) begin
        r_held <= ~r_held;
      end
    end
  end

  assign o_held = r_held;
  assign o_rise = w_toggle && !r_held;
  assign o_fall = w_toggle && r_held;

endmodule

// File: rtl/key_conditioner.sv
// Debounces four game keys and turns presses into single-cycle action strobes,
// with optional per-key auto-repeat (IDLE -> DELAY -> REPEAT).
module key_conditioner
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] pulse,
  output logic [NUM_KEYS-1:0] held
);

  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic          w_rise;
    logic          w_fall;
    rpt_state_t    r_state;
    rpt_state_t    w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [TW-1:0] w_timer_inc;
    logic          w_delay_hit;
    logic          w_rate_hit;
    logic          r_pulse;
    logic          w_pulse_next;

    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clock),
      .srst  (reset),
      .i_raw (key_raw[gi]),
      .o_held(held[gi]),
      .o_rise(w_rise),
      .o_fall(w_fall)
    );

    assign w_delay_hit = (r_timer == DELAY_LAST);
    assign w_rate_hit  = (r_timer == RATE_LAST);
    assign w_timer_inc = (r_timer == TIMER_MAX) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state <= RPT_IDLE;
        r_timer <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_timer <= w_timer_next;
        r_pulse <= w_pulse_next;
      end
    end

    // Unmasked keys never leave IDLE, so they strobe once per press.
    always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      unique case (r_state)
        RPT_IDLE: begin
          if (w_rise && REPEAT_MASK[gi]) begin
            w_state_next = RPT_DELAY;
            w_timer_next = '0;
          end
        end
        RPT_DELAY: begin
          if (w_delay_hit) begin
            w_state_next = RPT_REPEAT;
            w_timer_next = '0;
          end else begin
            w_timer_next = w_timer_inc;
          end
        end
        RPT_REPEAT: begin
          w_timer_next = w_rate_hit ? '0 : w_timer_inc;
        end
        default: begin
          w_state_next = RPT_IDLE;
          w_timer_next = '0;
        end
      endcase
      if (w_fall) begin
        w_state_next = RPT_IDLE;
        w_timer_next = '0;
      end
    end

    // A release landing on a repeat tick wins over the tick.
    always_comb begin
      w_pulse_next = 1'b0;
      unique case (r_state)
        RPT_IDLE:   w_pulse_next = w_rise;
        RPT_DELAY:  w_pulse_next = w_delay_hit;
        RPT_REPEAT: w_pulse_next = w_rate_hit;
        default:    w_pulse_next = 1'b0;
      endcase
      if (w_fall) begin
        w_pulse_next = 1'b0;
      end
    end

    assign pulse[gi] = r_pulse;
  end

endmodule
